adder_cla_pipe: RTL and testbench
=================================

Name: adder_cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- The WIDTH-bit operation is split into BLOCK-bit lookahead groups, one group per pipeline stage. The group carry is registered between stages, so the critical path is one BLOCK-bit CLA.
- Next generation of the fixed 4-bit combinational CLA, for datapaths that need wide operands at clock rate.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of BLOCK.
- BLOCK, 4, lookahead group width in bits; 1 <= BLOCK <= WIDTH.
- Derived localparam NSTAGE = WIDTH/BLOCK; this is the pipeline depth and the latency in cycles.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts the operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in; ignored when SUB=1.
- SUB  input  1  0 = A+B+CIN; 1 = A-B (A + ~B + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH+1  result; S[WIDTH] is carry-out (for SUB, 1 = no borrow).
- OVF  output  1  two's-complement signed overflow.

Behaviour:
- Reset: synchronous and active-low; it acts only on a rising clk edge with reset_n=0.
  - All stage valid bits, operand, partial-sum and carry registers clear to 0.
  - Outputs after reset: out_valid=0, S=0, OVF=0.
  - in_ready=0 while reset_n=0.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv & reset_n. Every stage register loads only when adv=1.
- Transfer: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Stage 0 input handling on transfer:
  - B is registered as B ^ {WIDTH{SUB}}.
  - The stage-0 carry-in is SUB ? 1 : CIN.
  - Stage valid = in_valid & in_ready. A cycle with adv=1 and no input transfer inserts a bubble (valid=0).
- Stage k (0..NSTAGE-1):
  - Computes bits [k*BLOCK +: BLOCK] with a combinational BLOCK-bit CLA from the registered carry.
  - Registers, into stage k+1: the group sum, the accumulated lower sum bits, the untouched upper operand bits, the group carry-out, and the sign bits needed for OVF.
- Latency: NSTAGE cycles from input transfer to out_valid, provided there is no backpressure. Throughput is 1 result/cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, the entire pipeline holds, S/OVF/out_valid stay stable, and in_ready=0. Bubbles are not collapsed during a stall.
- Arithmetic:
  - S = {carry_out, sum[WIDTH-1:0]}.
  - OVF = (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]), where B' is the inverted B when SUB=1.
  - Results wrap modulo 2^WIDTH; carry-out is reported in S[WIDTH].
- Ordering: results leave in acceptance order. There is no reordering and no dropping, except on reset.
- Reset mid-operation: in-flight operations are discarded. No partial result is ever presented; out_valid=0 on the cycle following the reset edge.
- BLOCK == WIDTH degenerates to a single registered stage, latency 1.
- SUB and CIN are sampled only on transfer. Changes while in_ready=0 have no effect.

Decomposition:
- Shared package adder_pkg: default WIDTH/BLOCK constants and a function computing NSTAGE. No typedefs needed.
- Sub-module adder_cla_block: combinational BLOCK-bit CLA with ports a, b, cin, s, cout, plus group P/G outputs for later reuse. It is instantiated once per stage in a generate loop.
- adder_cla_pipe holds only the stage registers and handshake logic.

Test Plan:
- WIDTH=8, BLOCK=4: A=0xFF, B=0x01, SUB=0, CIN=0, out_ready=1 -> out_valid exactly 2 cycles after transfer, S=0x100, OVF=0.
- A=0x05, B=0x07, SUB=1, CIN=1 (ignored) -> S=0x0FE (carry-out 0 = borrow), OVF=0. Then A=0x7F, B=0x01, SUB=0 -> S=0x080, OVF=1.
- Back-to-back stream of 4 transfers, (0x10+0x01), (0x20+0x02), (0x30+0x03), (0xF0+0x20), out_ready=1 -> out_valid high 4 consecutive cycles with S=0x011, 0x022, 0x033, 0x110 in order.
- Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, S/OVF/out_valid unchanged each cycle. Then out_ready=1 -> remaining results drain in order with no loss or duplication.
- Two operations in flight, reset_n=0 for one edge -> next cycle out_valid=0, S=0, and neither result ever appears. First transfer after reset_n=1 returns a correct result after NSTAGE cycles.
- Random sweep for WIDTH=16/BLOCK=4, WIDTH=32/BLOCK=8, WIDTH=8/BLOCK=8, with random out_ready -> every S/OVF matches a reference model over 10k transactions, in order.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and stage-count helper for the pipelined CLA adder
package adder_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;

  function automatic int calc_nstage(input int width, input int block);
    return width / block;
  endfunction
endpackage

// File: rtl/adder_cla_block.sv
// rtl/adder_cla_block.sv - combinational N-bit carry-lookahead group with group P/G
module adder_cla_block
  import adder_pkg::*;
#(
  parameter int N = DEFAULT_BLOCK
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         pg,
  output logic         gg
);
  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;
  logic         term;
  logic         gen;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products of g/p terms, not a ripple chain.
  always_comb begin
    c    = '0;
    term = 1'b0;
    gen  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    for (int j = 0; j < N; j++) begin
      term = g[j];
      for (int m = j + 1; m < N; m++) term = term & p[m];
      gen = gen | term;
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
  assign pg   = &p;
  assign gg   = gen;
endmodule

// File: rtl/adder_cla_pipe.sv
// rtl/adder_cla_pipe.sv - pipelined CLA adder/subtractor, one lookahead group per stage
module adder_cla_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S,
  output logic             OVF
);
  localparam int NSTAGE = calc_nstage(WIDTH, BLOCK);

  logic adv;

  // Register k holds an operation whose groups 0..k-1 are already summed.
  logic             vld_r [1:NSTAGE];
  logic [WIDTH-1:0] a_r   [1:NSTAGE];
  logic [WIDTH-1:0] b_r   [1:NSTAGE];
  logic [WIDTH-1:0] sum_r [1:NSTAGE];
  logic             c_r   [1:NSTAGE];

  logic             cur_v   [0:NSTAGE-1];
  logic [WIDTH-1:0] cur_a   [0:NSTAGE-1];
  logic [WIDTH-1:0] cur_b   [0:NSTAGE-1];
  logic [WIDTH-1:0] cur_sum [0:NSTAGE-1];
  logic [WIDTH-1:0] nxt_sum [0:NSTAGE-1];
  logic             cur_c   [0:NSTAGE-1];
  logic [BLOCK-1:0] grp_s   [0:NSTAGE-1];
  logic             grp_c   [0:NSTAGE-1];
  logic [NSTAGE-1:0] unused_pg;
  logic [NSTAGE-1:0] unused_gg;

  assign adv      = ~vld_r[NSTAGE] | out_ready;
  assign in_ready = adv & reset_n;

  always_comb begin
    cur_v[0]   = in_valid & in_ready;
    cur_a[0]   = A;
    cur_b[0]   = B ^ {WIDTH{SUB}};
    cur_c[0]   = SUB | CIN;
    cur_sum[0] = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      cur_v[k]   = vld_r[k];
      cur_a[k]   = a_r[k];
      cur_b[k]   = b_r[k];
      cur_c[k]   = c_r[k];
      cur_sum[k] = sum_r[k];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      nxt_sum[k] = cur_sum[k];
      nxt_sum[k][k*BLOCK +: BLOCK] = grp_s[k];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    adder_cla_block #(.N(BLOCK)) u_cla (
      .a    (cur_a[k][k*BLOCK +: BLOCK]),
      .b    (cur_b[k][k*BLOCK +: BLOCK]),
      .cin  (cur_c[k]),
      .s    (grp_s[k]),
      .cout (grp_c[k]),
      .pg   (unused_pg[k]),
      .gg   (unused_gg[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        vld_r[k] <= 1'b0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        sum_r[k] <= '0;
        c_r[k]   <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSTAGE; k++) begin
        vld_r[k+1] <= cur_v[k];
        a_r[k+1]   <= cur_a[k];
        b_r[k+1]   <= cur_b[k];
        sum_r[k+1] <= nxt_sum[k];
        c_r[k+1]   <= grp_c[k];
      end
    end
  end

  assign out_valid = vld_r[NSTAGE];
  assign S         = {c_r[NSTAGE], sum_r[NSTAGE]};
  assign OVF       = (a_r[NSTAGE][WIDTH-1] == b_r[NSTAGE][WIDTH-1]) &
                     (sum_r[NSTAGE][WIDTH-1] != a_r[NSTAGE][WIDTH-1]);
endmodule

// File: tb/tb_adder_cla_pipe.sv
// tb/tb_adder_cla_pipe.sv - directed and randomised checks of adder_cla_pipe
module tb_adder_cla_pipe;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // WIDTH=8, BLOCK=4 instance for the directed scenarios
  logic       d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_ovf;
  logic [7:0] d_a, d_b;
  logic [8:0] d_s;

  adder_cla_pipe #(.WIDTH(8), .BLOCK(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_a), .B(d_b), .CIN(d_cin), .SUB(d_sub), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .S(d_s), .OVF(d_ovf)
  );

  // index 0: 16/4, 1: 32/8, 2: 8/8
  logic        sw_in_valid [3];
  logic        sw_in_ready [3];
  logic [31:0] sw_a [3];
  logic [31:0] sw_b [3];
  logic        sw_cin [3];
  logic        sw_sub [3];
  logic        sw_out_valid [3];
  logic        sw_out_ready [3];
  logic [32:0] sw_s [3];
  logic        sw_ovf [3];
  logic [16:0] s16;
  logic [32:0] s32;
  logic [8:0]  s88;

  assign sw_s[0] = {16'b0, s16};
  assign sw_s[1] = s32;
  assign sw_s[2] = {24'b0, s88};

  adder_cla_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .A(sw_a[0][15:0]), .B(sw_b[0][15:0]), .CIN(sw_cin[0]), .SUB(sw_sub[0]),
    .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]), .S(s16), .OVF(sw_ovf[0])
  );

  adder_cla_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .A(sw_a[1]), .B(sw_b[1]), .CIN(sw_cin[1]), .SUB(sw_sub[1]),
    .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]), .S(s32), .OVF(sw_ovf[1])
  );

  adder_cla_pipe #(.WIDTH(8), .BLOCK(8)) dut88 (
    .clk(clk), .reset_n(reset_n), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .A(sw_a[2][7:0]), .B(sw_b[2][7:0]), .CIN(sw_cin[2]), .SUB(sw_sub[2]),
    .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]), .S(s88), .OVF(sw_ovf[2])
  );

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
    d_in_valid = 1'b1;
    d_a = a;
    d_b = b;
    d_sub = sub;
    d_cin = cin;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b0 || d_s !== 9'h000 || d_ovf !== 1'b0 || d_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b S=%h OVF=%b in_ready=%b, expected 0 000 0 0",
               d_out_valid, d_s, d_ovf, d_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sw_out_valid[i] !== 1'b0 || sw_s[i] !== 33'h0) begin
        miscompares++;
        $display("FAIL reset_state_sweep%0d: out_valid=%b S=%h, expected 0 0", i, sw_out_valid[i], sw_s[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (d_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b, expected 1", d_in_ready);
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    d_out_ready = 1'b1;
    drive8(8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: out_valid=%b, expected 0 one cycle after transfer", d_out_valid);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_s !== 9'h100 || d_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: out_valid=%b S=%h OVF=%b, expected 1 100 0", d_out_valid, d_s, d_ovf);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_bubble: out_valid=%b, expected 0", d_out_valid);
    end
  endtask

  task automatic test_sub_ovf;
    @(negedge clk);
    drive8(8'h05, 8'h07, 1'b1, 1'b1);
    @(negedge clk);
    drive8(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_s !== 9'h0FE || d_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow: out_valid=%b S=%h OVF=%b, expected 1 0fe 0", d_out_valid, d_s, d_ovf);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_s !== 9'h080 || d_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL add_overflow: out_valid=%b S=%h OVF=%b, expected 1 080 1", d_out_valid, d_s, d_ovf);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta [4] = '{8'h10, 8'h20, 8'h30, 8'hF0};
    logic [7:0] tb [4] = '{8'h01, 8'h02, 8'h03, 8'h20};
    logic [8:0] ts [4] = '{9'h011, 9'h022, 9'h033, 9'h110};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 4) drive8(ta[i], tb[i], 1'b0, 1'b0);
      else d_in_valid = 1'b0;
      #1;
      if (i >= 2 && i <= 5) begin
        vectors++;
        if (d_out_valid !== 1'b1 || d_s !== ts[i-2] || d_ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_result%0d: out_valid=%b S=%h OVF=%b, expected 1 %h 0",
                   i - 2, d_out_valid, d_s, d_ovf, ts[i-2]);
        end
      end else if (i == 1 || i == 6) begin
        vectors++;
        if (d_out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: out_valid=%b, expected 0", i, d_out_valid);
        end
      end
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    d_out_ready = 1'b1;
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_out_ready = 1'b0;
      drive8(8'hFF, 8'hFF, i[0], 1'b1);
      #1;
      vectors++;
      if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_s !== 9'h003 || d_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: in_ready=%b out_valid=%b S=%h OVF=%b, expected 0 1 003 0",
                 i, d_in_ready, d_out_valid, d_s, d_ovf);
      end
    end
    @(negedge clk);
    d_out_ready = 1'b1;
    drive8(8'h0A, 8'h03, 1'b1, 1'b0);
    #1;
    vectors++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b1 || d_s !== 9'h003) begin
      miscompares++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b S=%h, expected 1 1 003", d_in_ready, d_out_valid, d_s);
    end
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_s !== 9'h100 || d_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_drain1: out_valid=%b S=%h OVF=%b, expected 1 100 1", d_out_valid, d_s, d_ovf);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b1 || d_s !== 9'h107 || d_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain2: out_valid=%b S=%h OVF=%b, expected 1 107 0", d_out_valid, d_s, d_ovf);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (d_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain_end: out_valid=%b, expected 0", d_out_valid);
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    sw_out_ready[0] = 1'b1;
    sw_in_valid[0] = 1'b1;
    sw_sub[0] = 1'b0;
    sw_cin[0] = 1'b0;
    sw_a[0] = 32'h1234;
    sw_b[0] = 32'h1111;
    @(negedge clk);
    sw_a[0] = 32'hFFFF;
    sw_b[0] = 32'h0001;
    @(negedge clk);
    sw_in_valid[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (sw_in_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_ready_in_reset: in_ready=%b, expected 0", sw_in_ready[0]);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (sw_out_valid[0] !== 1'b0 || sw_s[0] !== 33'h0 || sw_ovf[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_after_reset: out_valid=%b S=%h OVF=%b, expected 0 0 0",
               sw_out_valid[0], sw_s[0], sw_ovf[0]);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (sw_out_valid[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_discard%0d: out_valid=%b S=%h, expected out_valid 0", i, sw_out_valid[0], sw_s[0]);
      end
    end
    @(negedge clk);
    sw_in_valid[0] = 1'b1;
    sw_a[0] = 32'h7FFF;
    sw_b[0] = 32'h0001;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      sw_in_valid[0] = 1'b0;
      #1;
      vectors++;
      if (i < 4) begin
        if (sw_out_valid[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL midop_latency%0d: out_valid=%b, expected 0", i, sw_out_valid[0]);
        end
      end else if (sw_out_valid[0] !== 1'b1 || sw_s[0] !== 33'h08000 || sw_ovf[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL midop_first_result: out_valid=%b S=%h OVF=%b, expected 1 08000 1",
                 sw_out_valid[0], sw_s[0], sw_ovf[0]);
      end
    end
  endtask

  task automatic test_sweep(input int id, input int w, input int n);
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [63:0] mask, smask, a, b, bb, sum;
    logic        sub, cin, ovf;
    int          sent, got, budget;
    sent = 0;
    got = 0;
    budget = 0;
    mask = (64'd1 << w) - 64'd1;
    smask = (mask << 1) | 64'd1;
    while (got < n && budget < n * 4 + 100) begin
      @(negedge clk);
      budget++;
      sw_out_ready[id] = ($urandom_range(0, 3) != 0);
      sw_in_valid[id] = (sent < n) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: a = mask;
        1: a = 64'd1 << (w - 1);
        default: a = {32'b0, $urandom} & mask;
      endcase
      case ($urandom_range(0, 7))
        0: b = mask;
        1: b = 64'd0;
        default: b = {32'b0, $urandom} & mask;
      endcase
      sub = $urandom_range(0, 1) == 1;
      cin = $urandom_range(0, 1) == 1;
      sw_a[id] = a[31:0];
      sw_b[id] = b[31:0];
      sw_sub[id] = sub;
      sw_cin[id] = cin;
      #1;
      if (sw_out_valid[id] && sw_out_ready[id]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sweep%0d_extra: S=%h OVF=%b with no outstanding operation", id, sw_s[id], sw_ovf[id]);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (sw_s[id] !== e[32:0] || sw_ovf[id] !== e[33]) begin
            miscompares++;
            $display("FAIL sweep%0d_result%0d: S=%h OVF=%b, expected S=%h OVF=%b",
                     id, got, sw_s[id], sw_ovf[id], e[32:0], e[33]);
          end
        end
      end
      if (sw_in_valid[id] && sw_in_ready[id]) begin
        bb = sub ? (~b & mask) : b;
        sum = a + bb + {63'b0, sub | cin};
        ovf = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
        e = {ovf, sum[32:0] & smask[32:0]};
        exp_q.push_back(e);
        sent++;
      end
    end
    sw_in_valid[id] = 1'b0;
    vectors++;
    if (got != n || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sweep%0d_count: received %0d results with %0d outstanding, expected %0d and 0",
               id, got, exp_q.size(), n);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    d_in_valid = 1'b0;
    d_a = '0;
    d_b = '0;
    d_cin = 1'b0;
    d_sub = 1'b0;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw_in_valid[i] = 1'b0;
      sw_a[i] = '0;
      sw_b[i] = '0;
      sw_cin[i] = 1'b0;
      sw_sub[i] = 1'b0;
      sw_out_ready[i] = 1'b1;
    end
    test_reset;
    test_basic;
    test_sub_ovf;
    test_back_to_back;
    test_stall;
    test_reset_midop;
    test_sweep(0, 16, 3400);
    test_sweep(1, 32, 3300);
    test_sweep(2, 8, 3300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
